// File: rtl/pe_array_pkg.sv
// -----------------------------------------------------------------------------
// pe_array_pkg
// Shared constants and the sequencer FSM encoding for the PE-array front end.
//   Data_width : element / partial-sum width
//   WORD_SIZE  : packed word of NUM_PE elements
//   NUM_PE     : chained PE count (skew depth and result latency)
// -----------------------------------------------------------------------------
package pe_array_pkg;

    localparam int Data_width = 8;
    localparam int NUM_PE     = 9;
    localparam int WORD_SIZE  = NUM_PE * Data_width;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

endpackage

// File: rtl/skew_line.sv
// -----------------------------------------------------------------------------
// skew_line
// Fixed-depth shift register that delays one array lane by DEPTH cycles.
// Clears to zero on reset so no stale element reaches the array.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   d     : lane element in
//   q     : lane element delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/pe_array_sequencer.sv
// -----------------------------------------------------------------------------
// pe_array_sequencer
// Front-end sequencer for a chain of NUM_PE processing elements: loads a weight
// word, streams ifmap windows through a per-lane skew, and returns the final
// partial sum of each accepted window as a single-cycle result strobe.
//   iClk / iRest_n          : clock, synchronous active-low reset
//   w_valid/w_data/w_ready  : weight word handshake
//   win_valid/win_data/
//   win_ready               : ifmap window handshake
//   enable_w, Run           : array weight-load strobe and compute enable
//   Weight_f_top            : registered weights to the array
//   Ifmap_f_left            : skewed elements, slice k to PE k
//   Psum_t_down             : final partial sum from the last PE
//   res_valid / res_data    : result strobe and value (no backpressure)
//   busy                    : high outside IDLE
// -----------------------------------------------------------------------------
module pe_array_sequencer #(
    parameter int Data_width = pe_array_pkg::Data_width,
    parameter int WORD_SIZE  = pe_array_pkg::WORD_SIZE,
    parameter int NUM_PE     = pe_array_pkg::NUM_PE
) (
    input  logic                  iClk,
    input  logic                  iRest_n,
    input  logic                  w_valid,
    input  logic [WORD_SIZE-1:0]  w_data,
    output logic                  w_ready,
    input  logic                  win_valid,
    input  logic [WORD_SIZE-1:0]  win_data,
    output logic                  win_ready,
    output logic                  enable_w,
    output logic                  Run,
    output logic [WORD_SIZE-1:0]  Weight_f_top,
    output logic [WORD_SIZE-1:0]  Ifmap_f_left,
    input  logic [Data_width-1:0] Psum_t_down,
    output logic                  res_valid,
    output logic [Data_width-1:0] res_data,
    output logic                  busy
);

    import pe_array_pkg::*;

    state_t state_q, state_d;

    logic w_ready_c, win_ready_c, enable_w_c, run_c, busy_c;
    logic w_fire, win_fire;

    // One token per accepted window; the last stage lines up with the
    // array's final partial sum for that window.
    logic [NUM_PE:0]      tok_q;
    logic                 pipe_empty;
    logic [WORD_SIZE-1:0] lane_in_q;

    assign pipe_empty = ~|tok_q;
    assign w_fire     = w_valid   & w_ready_c;
    assign win_fire   = win_valid & win_ready_c;

    always_ff @(posedge iClk) begin
        if (!iRest_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (w_fire)  state_d = ST_LOAD;
            ST_LOAD:                state_d = ST_STREAM;
            ST_STREAM: if (w_valid) state_d = ST_DRAIN;
            ST_DRAIN:  if (w_fire)  state_d = ST_LOAD;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready_c   = 1'b0;
        win_ready_c = 1'b0;
        enable_w_c  = 1'b0;
        run_c       = 1'b0;
        busy_c      = 1'b1;
        case (state_q)
            ST_IDLE: begin
                w_ready_c = 1'b1;
                busy_c    = 1'b0;
            end
            ST_LOAD:   enable_w_c = 1'b1;
            ST_STREAM: begin
                run_c       = 1'b1;
                // A pending weight word blocks new windows so the array is
                // drained before its weights change.
                win_ready_c = ~w_valid;
            end
            ST_DRAIN: begin
                run_c     = 1'b1;
                w_ready_c = pipe_empty;
            end
            default: busy_c = 1'b0;
        endcase
    end

    // Outputs are forced low while reset is asserted, not only after the edge.
    assign w_ready   = w_ready_c   & iRest_n;
    assign win_ready = win_ready_c & iRest_n;
    assign enable_w  = enable_w_c  & iRest_n;
    assign Run       = run_c       & iRest_n;
    assign busy      = busy_c      & iRest_n;
    assign res_valid = tok_q[NUM_PE] & iRest_n;
    assign res_data  = res_valid ? Psum_t_down : '0;

    always_ff @(posedge iClk) begin
        if (!iRest_n)    Weight_f_top <= '0;
        else if (w_fire) Weight_f_top <= w_data;
    end

    always_ff @(posedge iClk) begin
        if (!iRest_n) tok_q <= '0;
        else          tok_q <= {tok_q[NUM_PE-1:0], win_fire};
    end

    // Input stage: captures the accepted window, otherwise injects a zero
    // bubble into every lane.
    always_ff @(posedge iClk) begin
        if (!iRest_n)      lane_in_q <= '0;
        else if (win_fire) lane_in_q <= win_data;
        else               lane_in_q <= '0;
    end

    assign Ifmap_f_left[Data_width-1:0] = lane_in_q[Data_width-1:0];

    for (genvar k = 1; k < NUM_PE; k++) begin : g_skew
        skew_line #(
            .DEPTH (k),
            .W     (Data_width)
        ) u_skew (
            .clk   (iClk),
            .rst_n (iRest_n),
            .d     (lane_in_q[k*Data_width +: Data_width]),
            .q     (Ifmap_f_left[k*Data_width +: Data_width])
        );
    end

    if (WORD_SIZE > NUM_PE * Data_width) begin : g_pad
        assign Ifmap_f_left[WORD_SIZE-1:NUM_PE*Data_width] = '0;
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
`timescale 1ns/1ps
module tb_pe_array_sequencer;

    localparam int DW = 8;
    localparam int NP = 9;
    localparam int WS = 72;

    logic          iClk      = 1'b0;
    logic          iRest_n   = 1'b0;
    logic          w_valid   = 1'b0;
    logic [WS-1:0] w_data    = '0;
    logic          win_valid = 1'b0;
    logic [WS-1:0] win_data  = '0;
    logic [DW-1:0] Psum_t_down;

    logic          w_ready, win_ready, enable_w, Run, res_valid, busy;
    logic [WS-1:0] Weight_f_top, Ifmap_f_left;
    logic [DW-1:0] res_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [DW-1:0] res_q[$];
    int            rcyc_q[$];

    pe_array_sequencer #(
        .Data_width (DW),
        .WORD_SIZE  (WS),
        .NUM_PE     (NP)
    ) dut (
        .iClk         (iClk),
        .iRest_n      (iRest_n),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_ready      (w_ready),
        .win_valid    (win_valid),
        .win_data     (win_data),
        .win_ready    (win_ready),
        .enable_w     (enable_w),
        .Run          (Run),
        .Weight_f_top (Weight_f_top),
        .Ifmap_f_left (Ifmap_f_left),
        .Psum_t_down  (Psum_t_down),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .busy         (busy)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    // Behavioural weight-stationary PE chain: PE k adds w_k * x_k to the
    // partial sum arriving from PE k-1, one register per PE.
    logic [DW-1:0] pe_w  [NP];
    logic [DW-1:0] pe_ps [NP];

    always @(posedge iClk) begin
        if (enable_w)
            for (int k = 0; k < NP; k++) pe_w[k] <= Weight_f_top[k*DW +: DW];
        if (Run) begin
            pe_ps[0] <= DW'(pe_w[0] * Ifmap_f_left[DW-1:0]);
            for (int k = 1; k < NP; k++)
                pe_ps[k] <= DW'(pe_ps[k-1] + pe_w[k] * Ifmap_f_left[k*DW +: DW]);
        end
    end

    assign Psum_t_down = pe_ps[NP-1];

    always @(negedge iClk) begin
        if (res_valid) begin
            res_q.push_back(res_data);
            rcyc_q.push_back(cyc);
        end
    end

    function automatic logic [WS-1:0] fill(input logic [7:0] b);
        return {NP{b}};
    endfunction

    task automatic check_val(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge iClk);
            #1;
        end
    endtask

    task automatic send_win(input logic [WS-1:0] d, input string tag, output int hs);
        win_valid = 1'b1;
        win_data  = d;
        #1;
        check_val(tag, WS'(win_ready), WS'(1));
        hs = cyc;
        @(posedge iClk);
        #1;
        win_valid = 1'b0;
        win_data  = '0;
    endtask

    task automatic wait_res(input int n, input string tag);
        for (int i = 0; i < 40 && res_q.size() < n; i++) @(posedge iClk);
        #1;
        check_val(tag, WS'(res_q.size()), WS'(n));
    endtask

    task automatic clear_res();
        res_q.delete();
        rcyc_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, hs1, hs2, ld;
        bit found;

        // Reset state
        tick(3);
        check_val("rst_w_ready",   WS'(w_ready),   WS'(0));
        check_val("rst_win_ready", WS'(win_ready), WS'(0));
        check_val("rst_busy",      WS'(busy),      WS'(0));
        check_val("rst_run",       WS'(Run),       WS'(0));
        check_val("rst_enable_w",  WS'(enable_w),  WS'(0));
        check_val("rst_res_valid", WS'(res_valid), WS'(0));
        check_val("rst_wtop",      Weight_f_top,   WS'(0));
        iRest_n = 1'b1;
        #1;
        check_val("idle_w_ready",  WS'(w_ready),   WS'(1));
        check_val("idle_win_rdy",  WS'(win_ready), WS'(0));

        // Load weights 0x01
        w_valid = 1'b1;
        w_data  = fill(8'h01);
        tick(1);
        w_valid = 1'b0;
        check_val("load_enable_w", WS'(enable_w),  WS'(1));
        check_val("load_run",      WS'(Run),       WS'(0));
        check_val("load_busy",     WS'(busy),      WS'(1));
        check_val("load_w_ready",  WS'(w_ready),   WS'(0));
        check_val("load_wtop",     Weight_f_top,   fill(8'h01));
        tick(1);
        check_val("strm_run",      WS'(Run),       WS'(1));
        check_val("strm_enable_w", WS'(enable_w),  WS'(0));

        // Single window of 0x02: 9 * 1 * 2 = 0x12, 10 cycles later
        clear_res();
        send_win(fill(8'h02), "a_rdy", hs0);
        wait_res(1, "a_cnt");
        if (res_q.size() >= 1) begin
            check_val("a_data", WS'(res_q[0]), WS'(8'h12));
            check_val("a_lat",  WS'(rcyc_q[0] - hs0), WS'(10));
        end
        tick(3);
        check_val("a_single_pulse", WS'(res_q.size()), WS'(1));

        // Back-to-back windows 0x01, 0x02, 0x03 -> 0x09, 0x12, 0x1B
        clear_res();
        send_win(fill(8'h01), "b_rdy0", hs0);
        send_win(fill(8'h02), "b_rdy1", hs1);
        send_win(fill(8'h03), "b_rdy2", hs2);
        wait_res(3, "b_cnt");
        if (res_q.size() >= 3) begin
            check_val("b_data0", WS'(res_q[0]), WS'(8'h09));
            check_val("b_data1", WS'(res_q[1]), WS'(8'h12));
            check_val("b_data2", WS'(res_q[2]), WS'(8'h1B));
            check_val("b_lat0",  WS'(rcyc_q[0] - hs0), WS'(10));
            check_val("b_gap1",  WS'(rcyc_q[1] - rcyc_q[0]), WS'(1));
            check_val("b_gap2",  WS'(rcyc_q[2] - rcyc_q[0]), WS'(2));
        end

        // Weight change with a window in flight and a competing window
        clear_res();
        send_win(fill(8'h02), "c_rdy0", hs0);
        w_valid   = 1'b1;
        w_data    = fill(8'h10);
        win_valid = 1'b1;
        win_data  = fill(8'h02);
        #1;
        check_val("c_refuse",      WS'(win_ready), WS'(0));
        check_val("c_strm_w_rdy",  WS'(w_ready),   WS'(0));
        found = 1'b0;
        ld    = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i == 0) begin
                check_val("c_drain_run",  WS'(Run),     WS'(1));
                check_val("c_drain_wtop", Weight_f_top, fill(8'h01));
                check_val("c_drain_wrdy", WS'(w_ready), WS'(0));
            end
            if (enable_w) begin
                found = 1'b1;
                ld    = cyc;
                break;
            end
        end
        check_val("c_load_seen", WS'(found), WS'(1));
        check_val("c_load_cyc",  WS'(ld - hs0), WS'(12));
        check_val("c_load_wtop", Weight_f_top, fill(8'h10));
        check_val("c_load_run",  WS'(Run), WS'(0));
        w_valid = 1'b0;
        tick(1);
        check_val("c_enw_pulse", WS'(enable_w), WS'(0));
        check_val("c_strm_run",  WS'(Run), WS'(1));
        send_win(fill(8'h02), "c_rdy1", hs1);
        wait_res(2, "c_cnt");
        if (res_q.size() >= 2) begin
            check_val("c_old_data", WS'(res_q[0]), WS'(8'h12));
            check_val("c_old_lat",  WS'(rcyc_q[0] - hs0), WS'(10));
            check_val("c_new_data", WS'(res_q[1]), WS'(8'h20));
            check_val("c_new_lat",  WS'(rcyc_q[1] - hs1), WS'(10));
        end

        // Reset 4 cycles after a handshake discards the window
        clear_res();
        send_win(fill(8'h03), "d_rdy", hs0);
        tick(3);
        iRest_n = 1'b0;
        #1;
        check_val("d_rst_res_valid", WS'(res_valid), WS'(0));
        check_val("d_rst_res_data",  WS'(res_data),  WS'(0));
        check_val("d_rst_busy",      WS'(busy),      WS'(0));
        check_val("d_rst_run",       WS'(Run),       WS'(0));
        check_val("d_rst_enable_w",  WS'(enable_w),  WS'(0));
        check_val("d_rst_w_ready",   WS'(w_ready),   WS'(0));
        check_val("d_rst_win_ready", WS'(win_ready), WS'(0));
        tick(1);
        iRest_n = 1'b1;
        #1;
        check_val("d_idle_busy",  WS'(busy),    WS'(0));
        check_val("d_idle_wrdy",  WS'(w_ready), WS'(1));
        check_val("d_idle_wtop",  Weight_f_top, WS'(0));
        tick(20);
        check_val("d_no_result",  WS'(res_q.size()), WS'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
